// File: rtl/sel_arb_reg.sv
// sel_arb_reg: round-robin arbitrated, byte-maskable shared register.
//   clk     : clock, all state updates on the rising edge
//   rst_n   : asynchronous active-low reset
//   req     : per-channel write request (NCH bits)
//   wdata   : per-channel write data, channel c in [c*WIDTH +: WIDTH]
//   bmask   : per-channel byte enables, channel c in [c*WIDTH/8 +: WIDTH/8]
//   grant   : combinational one-hot grant for the coming edge (zero if idle)
//   q       : stored register value
//   upd     : pulse for the cycle after each write edge
//   upd_ch  : index of the most recently written channel
//   wr_cnt  : saturating count of write edges
module sel_arb_reg #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            req,
  input  logic [NCH*WIDTH-1:0]      wdata,
  input  logic [NCH*(WIDTH/8)-1:0]  bmask,
  output logic [NCH-1:0]            grant,
  output logic [WIDTH-1:0]          q,
  output logic                      upd,
  output logic [$clog2(NCH)-1:0]    upd_ch,
  output logic [15:0]               wr_cnt
);

  localparam int unsigned PW    = $clog2(NCH);
  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned CNT_W = 16;

  logic [PW-1:0]    ptr_r;
  logic [PW-1:0]    ptr_nxt;
  logic [PW-1:0]    win;
  logic [PW-1:0]    idx;
  logic             win_vld;
  logic [WIDTH-1:0] wsel;
  logic [NB-1:0]    msel;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt;
  logic             upd_r;
  logic [PW-1:0]    upd_ch_r;
  logic [CNT_W-1:0] wr_cnt_r;

  // Round-robin scan starting at ptr; the first requester found wins.
  always_comb begin
    grant   = '0;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = PW'((32'(ptr_r) + i) % NCH);
      if (!win_vld && req[idx]) begin
        win_vld    = 1'b1;
        win        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

  // Pointer moves to the channel just after the winner, wrapping at NCH.
  always_comb begin
    ptr_nxt = ptr_r;
    if (win_vld) begin
      ptr_nxt = (win == PW'(NCH - 1)) ? '0 : win + PW'(1);
    end
  end

  // Select the winner's data/mask and merge byte-wise into the stored value.
  always_comb begin
    wsel = '0;
    msel = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (PW'(c) == win) begin
        wsel = wdata[c*WIDTH +: WIDTH];
        msel = bmask[c*NB +: NB];
      end
    end
    q_nxt = q_r;
    for (int unsigned k = 0; k < NB; k++) begin
      if (msel[k]) begin
        q_nxt[k*8 +: 8] = wsel[k*8 +: 8];
      end
    end
  end

  // State registers; a masked-off write still counts as a write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r    <= '0;
      q_r      <= RESET_VAL;
      upd_r    <= 1'b0;
      upd_ch_r <= '0;
      wr_cnt_r <= '0;
    end else begin
      ptr_r <= ptr_nxt;
      upd_r <= win_vld;
      if (win_vld) begin
        q_r      <= q_nxt;
        upd_ch_r <= win;
        if (wr_cnt_r != '1) begin
          wr_cnt_r <= wr_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  assign q      = q_r;
  assign upd    = upd_r;
  assign upd_ch = upd_ch_r;
  assign wr_cnt = wr_cnt_r;

endmodule

// File: tb/tb_sel_arb_reg.sv
// Self-checking bench for sel_arb_reg (WIDTH=32, NCH=4, RESET_VAL=0):
// random and directed stimulus compared against a behavioural model.
module tb_sel_arb_reg;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req;
  logic [127:0] wdata;
  logic [15:0]  bmask;
  logic [3:0]   grant;
  logic [31:0]  q;
  logic         upd;
  logic [1:0]   upd_ch;
  logic [15:0]  wr_cnt;

  sel_arb_reg #(.WIDTH(32), .NCH(4), .RESET_VAL(32'h0)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .wdata  (wdata),
    .bmask  (bmask),
    .grant  (grant),
    .q      (q),
    .upd    (upd),
    .upd_ch (upd_ch),
    .wr_cnt (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: winner is the first requesting channel scanning from p, or -1.
  function automatic int mwin(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mmerge(input logic [31:0] old, input logic [127:0] d,
                                         input logic [15:0] m, input int w);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) begin
      if (m[w*4 + k]) r[k*8 +: 8] = d[w*32 + k*8 +: 8];
    end
    return r;
  endfunction

  logic [31:0] m_q;
  int          m_ptr;
  logic        m_upd;
  int          m_upd_ch;
  logic [15:0] m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= 32'h0; m_ptr <= 0; m_upd <= 1'b0; m_upd_ch <= 0; m_cnt <= 16'h0;
    end else if (mwin(req, m_ptr) >= 0) begin
      m_q      <= mmerge(m_q, wdata, bmask, mwin(req, m_ptr));
      m_ptr    <= (mwin(req, m_ptr) + 1) % 4;
      m_upd    <= 1'b1;
      m_upd_ch <= mwin(req, m_ptr);
      m_cnt    <= (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
    end else begin
      m_upd <= 1'b0;
    end
  end

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("grant",  32'(grant),  (mwin(req, m_ptr) < 0) ? 32'h0 : (32'h1 << mwin(req, m_ptr)));
      check("q",      q,           m_q);
      check("upd",    32'(upd),    32'(m_upd));
      check("upd_ch", 32'(upd_ch), 32'(m_upd_ch));
      check("wr_cnt", 32'(wr_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic rnd_data();
    for (int c = 0; c < 4; c++) wdata[c*32 +: 32] = $urandom;
    bmask = 16'($urandom);
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req   = 4'h0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'h0;
    wdata = '0;
    bmask = '0;
    repeat (2) @(posedge clk);
    step();
    chk_en = 1'b1;
    rst_n  = 1'b1;

    // Reset then idle.
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_q", q, 32'h0);
      check("idle_upd", 32'(upd), 32'h0);
      check("idle_cnt", 32'(wr_cnt), 32'h0);
      check("idle_grant", 32'(grant), 32'h0);
    end

    // Single masked write on channel 1.
    rnd_data();
    req = 4'b0010;
    wdata[63:32] = 32'hA5A5_1234;
    bmask[7:4]   = 4'b0101;
    #1;
    check("wr1_grant", 32'(grant), 32'h2);
    step();
    req = 4'h0;
    check("wr1_q", q, 32'h00A5_0034);
    check("wr1_upd", 32'(upd), 32'h1);
    check("wr1_upd_ch", 32'(upd_ch), 32'h1);
    check("wr1_cnt", 32'(wr_cnt), 32'h1);
    step();
    check("wr1_upd_drop", 32'(upd), 32'h0);
    check("wr1_upd_ch_hold", 32'(upd_ch), 32'h1);

    // All channels requesting: strict rotation, upd continuously high.
    do_reset();
    step();
    req = 4'hF;
    for (int i = 0; i < 8; i++) begin
      rnd_data();
      #1;
      check("rr_grant", 32'(grant), 32'h1 << (i % 4));
      step();
      check("rr_upd", 32'(upd), 32'h1);
    end
    check("rr_cnt", 32'(wr_cnt), 32'h8);
    req = 4'h0;

    // Pointer wrap: channel 2 wins, then 3, then 0.
    step();
    req = 4'b0100;
    step();
    req = 4'b1001;
    #1;
    check("wrap_g3", 32'(grant), 32'h8);
    step();
    check("wrap_g0", 32'(grant), 32'h1);
    step();
    req = 4'h0;

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step();
      req = 4'($urandom);
      if ($urandom_range(0, 4) == 0) req = 4'h0;
      rnd_data();
    end

    // Mid-cycle reset during a write stream.
    for (int i = 0; i < 20; i++) begin
      step();
      req = 4'($urandom) | 4'h1;
      rnd_data();
    end
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_q", q, 32'h0);
    check("mrst_cnt", 32'(wr_cnt), 32'h0);
    check("mrst_upd", 32'(upd), 32'h0);
    #1;
    rst_n = 1'b1;
    req = 4'b0110;
    #1;
    check("mrst_grant", 32'(grant), 32'h2);
    step();
    check("mrst_upd_ch", 32'(upd_ch), 32'h1);
    req = 4'h0;

    // Counter saturation.
    do_reset();
    req = 4'hF;
    for (int i = 0; i < 65534; i++) begin
      rnd_data();
      step();
    end
    check("sat_fffe", 32'(wr_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      rnd_data();
      step();
      check("sat_ffff", 32'(wr_cnt), 32'hFFFF);
    end
    req = 4'h0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
